// File: rtl/eeprom_slave.sv
// eeprom_slave: target side of a two-wire serial EEPROM bus, backed by a
// 2^ADDR_W x 8 memory. It decodes START / control byte / word address /
// data / STOP, stores written bytes, and serves current-address, random
// and sequential reads. The address pointer wraps from the top address to 0.
//
// Ports:
//   CLK        system clock, oversamples SCL/SDA (SCL must be >= 8x slower)
//   RESET      asynchronous, active-high reset
//   SCL        serial clock from the controller
//   SDA        open-drain serial data: driven only to 1'b0 or left at 1'bz
//   BUSY       high from a detected START until a detected STOP
//   STATE_DBG  current FSM state: 0 IDLE, 1 CTRL, 2 CTRL_ACK, 3 ADDR,
//              4 ADDR_ACK, 5 WDATA, 6 WDATA_ACK, 7 RDATA, 8 RDATA_ACK
//
// Handshake: there is no valid/ready pair here. A bus bit is valid on every
// detected SCL rising edge; this block only changes its SDA drive after a
// detected SCL falling edge, so its data is stable for the whole SCL high phase.
//
// ADDR_W must lie in 9..11: the control byte carries pointer bits [ADDR_W-1:8].
module eeprom_slave #(
  parameter logic [3:0] DEV_ID = 4'b1010,
  parameter int         ADDR_W = 11
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       BUSY,
  output logic [3:0] STATE_DBG
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CTRL      = 4'd1,
    S_CTRL_ACK  = 4'd2,
    S_ADDR      = 4'd3,
    S_ADDR_ACK  = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        scl_sync, sda_sync;
  logic              scl_hist, sda_hist;
  logic              ev_rise, ev_fall, ev_start, ev_stop;
  logic [7:0]        shreg_q;
  logic [3:0]        bit_cnt_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              sda_oe_q;
  logic              busy_q;
  logic [7:0]        mem [DEPTH];
  logic [7:0]        rd_byte;

  logic bus_evt, byte_done, id_ok, mem_we, rd_load;

  // Input synchronizers, one history flop, then registered bus events.
  // Idle bus level is high, so everything resets to 1 to avoid false edges.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
      ev_rise  <= 1'b0;
      ev_fall  <= 1'b0;
      ev_start <= 1'b0;
      ev_stop  <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[0], SCL};
      sda_sync <= {sda_sync[0], SDA};
      scl_hist <= scl_sync[1];
      sda_hist <= sda_sync[1];
      ev_rise  <= scl_sync[1] & ~scl_hist;
      ev_fall  <= ~scl_sync[1] & scl_hist;
      ev_start <= scl_sync[1] & scl_hist & ~sda_sync[1] & sda_hist;
      ev_stop  <= scl_sync[1] & scl_hist & sda_sync[1] & ~sda_hist;
    end
  end

  // In an event cycle sda_hist holds the SDA value seen when the event was
  // detected, so it is the sampled data bit for an SCL rise.
  assign bus_evt   = ev_start | ev_stop;
  assign byte_done = ev_fall & (bit_cnt_q == 4'd8);
  assign id_ok     = (shreg_q[7:4] == DEV_ID);
  assign rd_byte   = mem[ptr_q];

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; STOP and START override every state
  always_comb begin
    state_d = state_q;
    if (ev_stop) begin
      state_d = S_IDLE;
    end else if (ev_start) begin
      state_d = S_CTRL;
    end else begin
      case (state_q)
        S_IDLE:      state_d = S_IDLE;
        S_CTRL:      if (byte_done) state_d = id_ok ? S_CTRL_ACK : S_IDLE;
        S_CTRL_ACK:  if (ev_fall) state_d = shreg_q[0] ? S_RDATA : S_ADDR;
        S_ADDR:      if (byte_done) state_d = S_ADDR_ACK;
        S_ADDR_ACK:  if (ev_fall) state_d = S_WDATA;
        S_WDATA:     if (byte_done) state_d = S_WDATA_ACK;
        S_WDATA_ACK: if (ev_fall) state_d = S_WDATA;
        S_RDATA:     if (byte_done) state_d = S_RDATA_ACK;
        S_RDATA_ACK: begin
          // Master NACK ends the read at the 9th rise; ACK continues at the fall.
          if (ev_rise && sda_hist) state_d = S_IDLE;
          else if (ev_fall)        state_d = S_RDATA;
        end
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // Output / action decode
  always_comb begin
    mem_we    = ~bus_evt & byte_done & (state_q == S_WDATA);
    rd_load   = ~bus_evt & ev_fall &
                (((state_q == S_CTRL_ACK) & shreg_q[0]) | (state_q == S_RDATA_ACK));
    STATE_DBG = state_q;
    BUSY      = busy_q;
  end

  assign SDA = sda_oe_q ? 1'b0 : 1'bz;

  // Datapath: shift register, bit counter, pointer, SDA pull-down, busy flag
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shreg_q   <= 8'h00;
      bit_cnt_q <= 4'd0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else if (ev_stop) begin
      sda_oe_q  <= 1'b0;
      bit_cnt_q <= 4'd0;
      busy_q    <= 1'b0;
    end else if (ev_start) begin
      sda_oe_q  <= 1'b0;
      bit_cnt_q <= 4'd0;
      busy_q    <= 1'b1;
    end else if (rd_load) begin
      // Next read byte: first bit goes out now, pointer moves past it.
      shreg_q   <= rd_byte;
      sda_oe_q  <= ~rd_byte[7];
      bit_cnt_q <= 4'd0;
      ptr_q     <= ptr_q + PTR_ONE;
    end else begin
      case (state_q)
        S_CTRL, S_ADDR, S_WDATA: begin
          if (ev_rise && bit_cnt_q != 4'd8) begin
            shreg_q   <= {shreg_q[6:0], sda_hist};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
          if (byte_done) begin
            bit_cnt_q <= 4'd0;
            if (state_q == S_CTRL) begin
              if (id_ok) begin
                sda_oe_q <= 1'b1;
                if (!shreg_q[0]) ptr_q[ADDR_W-1:8] <= shreg_q[ADDR_W-8:1];
              end
            end else if (state_q == S_ADDR) begin
              sda_oe_q    <= 1'b1;
              ptr_q[7:0]  <= shreg_q;
            end else begin
              sda_oe_q <= 1'b1;
              ptr_q    <= ptr_q + PTR_ONE;
            end
          end
        end
        S_CTRL_ACK, S_ADDR_ACK, S_WDATA_ACK: begin
          if (ev_fall) sda_oe_q <= 1'b0;
        end
        S_RDATA: begin
          if (ev_rise && bit_cnt_q != 4'd8) bit_cnt_q <= bit_cnt_q + 4'd1;
          if (ev_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_q <= 1'b0;
            end else begin
              shreg_q  <= {shreg_q[6:0], 1'b0};
              sda_oe_q <= ~shreg_q[6];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Memory contents survive reset; the write lands as WDATA_ACK is entered.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[ptr_q] <= shreg_q;
  end

endmodule

// File: tb/tb_eeprom_slave.sv
// Bench for eeprom_slave: acts as the bus master, keeps a byte-array model
// of the EEPROM plus its address pointer, and compares every byte read back
// through an expected queue.
module tb_eeprom_slave;

  localparam int         Q       = 5;      // quarter SCL period in CLK cycles
  localparam logic [3:0] ST_IDLE = 4'd0;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_low;
  wire        sda;
  logic       busy;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  model_mem [2048];
  logic [10:0] model_ptr;
  logic [7:0]  exp_q [$];
  logic [7:0]  wbuf [8];
  logic [7:0]  rbuf [8];

  // Clock / bus wiring
  always #5 clk = ~clk;
  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  eeprom_slave #(.DEV_ID(4'b1010), .ADDR_W(11)) dut (
    .CLK(clk), .RESET(rst), .SCL(scl), .SDA(sda), .BUSY(busy), .STATE_DBG(state_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    m_low = 1'b1; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    m_low = 1'b0; tick(Q);
    tick(Q);
  endtask

  task automatic bit_cycle(input logic b, output logic r);
    m_low = ~b; tick(Q);
    scl = 1'b1; tick(Q);
    r = sda;    tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_cycle(d[i], r);
    bit_cycle(1'b1, r);
    ack = ~r;
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, r);
      d[i] = r;
    end
    bit_cycle(~master_ack, r);
  endtask

  // Write n bytes of wbuf starting at a; updates the model
  task automatic do_write(input logic [10:0] a, input int n, output int acks);
    logic ak;
    logic [10:0] p;
    acks = 0;
    i2c_start();
    send_byte({4'hA, a[10:8], 1'b0}, ak); if (ak) acks++;
    send_byte(a[7:0], ak);               if (ak) acks++;
    p = a;
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], ak); if (ak) acks++;
      model_mem[p] = wbuf[i];
      p = p + 11'd1;
    end
    i2c_stop();
    model_ptr = p;
  endtask

  // Random read of n bytes at a into rbuf (ACK all but the last)
  task automatic do_rand_read(input logic [10:0] a, input int n, output int acks);
    logic ak;
    acks = 0;
    i2c_start();
    send_byte({4'hA, a[10:8], 1'b0}, ak); if (ak) acks++;
    send_byte(a[7:0], ak);               if (ak) acks++;
    i2c_start();
    send_byte(8'hA1, ak);                if (ak) acks++;
    for (int i = 0; i < n; i++) recv_byte(i != n - 1, rbuf[i]);
    i2c_stop();
    model_ptr = a + 11'(n);
  endtask

  task automatic do_cur_read(input int n, output int acks);
    logic ak;
    acks = 0;
    i2c_start();
    send_byte(8'hA1, ak); if (ak) acks++;
    for (int i = 0; i < n; i++) recv_byte(i != n - 1, rbuf[i]);
    i2c_stop();
    model_ptr = model_ptr + 11'(n);
  endtask

  task automatic expect_bytes(input logic [10:0] a, input int n);
    logic [10:0] p;
    p = a;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_mem[p]);
      p = p + 11'd1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; scl = 1'b1; m_low = 1'b0;
    tick(3);
    n_checks++;
    if (sda !== 1'b1 || busy !== 1'b0 || state_dbg !== ST_IDLE) begin
      n_errors++;
      $display("FAIL reset_hold: sda=%b busy=%b state=%0d, expected sda=1 busy=0 state=0", sda, busy, state_dbg);
    end
    rst = 1'b0;
    tick(4);
    n_checks++;
    if (sda !== 1'b1 || busy !== 1'b0 || state_dbg !== ST_IDLE) begin
      n_errors++;
      $display("FAIL reset_release: sda=%b busy=%b state=%0d, expected sda=1 busy=0 state=0", sda, busy, state_dbg);
    end
  endtask

  task automatic test_write_random_read();
    int acks;
    logic ak;
    logic [7:0] d, e;
    wbuf[0] = 8'h3C;
    do_write(11'h05A, 1, acks);
    n_checks++;
    if (acks !== 3) begin n_errors++; $display("FAIL bw_acks: got %0d, expected 3", acks); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL bw_busy_after_stop: got %b, expected 0", busy); end
    expect_bytes(11'h05A, 1);
    acks = 0;
    i2c_start();
    send_byte(8'hA0, ak); if (ak) acks++;
    send_byte(8'h5A, ak); if (ak) acks++;
    i2c_start();
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL rr_busy: got %b, expected 1", busy); end
    send_byte(8'hA1, ak); if (ak) acks++;
    recv_byte(1'b0, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e || d !== 8'h3C) begin n_errors++; $display("FAIL rr_data: got %h, expected %h", d, e); end
    n_checks++;
    if (acks !== 3) begin n_errors++; $display("FAIL rr_acks: got %0d, expected 3", acks); end
    n_checks++;
    if (sda !== 1'b1 || state_dbg !== ST_IDLE) begin
      n_errors++; $display("FAIL rr_nack_release: sda=%b state=%0d, expected sda=1 state=0", sda, state_dbg);
    end
    i2c_stop();
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL rr_busy_stop: got %b, expected 0", busy); end
  endtask

  task automatic test_wrap();
    int acks;
    wbuf[0] = 8'h11; do_write(11'h7FF, 1, acks);
    wbuf[0] = 8'h22; do_write(11'h000, 1, acks);
    expect_bytes(11'h7FF, 2);
    do_rand_read(11'h7FF, 2, acks);
    for (int i = 0; i < 2; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (rbuf[i] !== e) begin n_errors++; $display("FAIL wrap_read[%0d]: got %h, expected %h", i, rbuf[i], e); end
    end
    // One burst written straight across the wrap point
    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom_range(0, 255));
    do_write(11'h7FE, 4, acks);
    n_checks++;
    if (acks !== 6) begin n_errors++; $display("FAIL wrap_burst_acks: got %0d, expected 6", acks); end
    expect_bytes(11'h7FE, 4);
    do_rand_read(11'h7FE, 4, acks);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (rbuf[i] !== e) begin n_errors++; $display("FAIL wrap_burst[%0d]: got %h, expected %h", i, rbuf[i], e); end
    end
  endtask

  task automatic test_wrong_id();
    int acks;
    logic ak;
    logic [7:0] e;
    i2c_start();
    send_byte(8'hB0, ak);
    n_checks++;
    if (ak !== 1'b0 || state_dbg !== ST_IDLE) begin
      n_errors++; $display("FAIL wrong_id_ack: ack=%b state=%0d, expected ack=0 state=0", ak, state_dbg);
    end
    send_byte(8'h5A, ak);
    n_checks++;
    if (ak !== 1'b0 || state_dbg !== ST_IDLE) begin
      n_errors++; $display("FAIL wrong_id_idle: ack=%b state=%0d, expected ack=0 state=0", ak, state_dbg);
    end
    i2c_stop();
    expect_bytes(11'h05A, 1);
    do_rand_read(11'h05A, 1, acks);
    e = exp_q.pop_front();
    n_checks++;
    if (rbuf[0] !== e) begin n_errors++; $display("FAIL wrong_id_mem: got %h, expected %h", rbuf[0], e); end
  endtask

  task automatic test_stop_mid_byte();
    int acks;
    logic ak, r;
    logic [7:0] e;
    wbuf[0] = 8'($urandom_range(0, 254));
    do_write(11'h010, 1, acks);
    i2c_start();
    send_byte(8'hA0, ak);
    send_byte(8'h10, ak);
    for (int i = 0; i < 4; i++) bit_cycle(1'b1, r);
    i2c_stop();
    n_checks++;
    if (state_dbg !== ST_IDLE || sda !== 1'b1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL stop_mid_state: state=%0d sda=%b busy=%b, expected 0/1/0", state_dbg, sda, busy);
    end
    expect_bytes(11'h010, 1);
    do_rand_read(11'h010, 1, acks);
    e = exp_q.pop_front();
    n_checks++;
    if (rbuf[0] !== e) begin n_errors++; $display("FAIL stop_mid_mem: got %h, expected %h", rbuf[0], e); end
  endtask

  task automatic test_async_reset();
    int acks;
    logic ak;
    logic [7:0] e;
    wbuf[0] = 8'h3C;
    do_write(11'h05A, 1, acks);
    i2c_start();
    send_byte(8'hA0, ak);
    send_byte(8'h5A, ak);
    i2c_start();
    send_byte(8'hA1, ak);
    // First read bit (bit 7 of 0x3C) is a 0, so the slave pulls SDA low now
    n_checks++;
    if (sda !== model_mem[11'h05A][7]) begin
      n_errors++; $display("FAIL arst_drive: sda=%b, expected %b", sda, model_mem[11'h05A][7]);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (sda !== 1'b1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL arst_immediate: sda=%b busy=%b, expected sda=1 busy=0", sda, busy);
    end
    tick(2);
    rst = 1'b0;
    m_low = 1'b0;
    tick(4);
    expect_bytes(11'h05A, 1);
    do_rand_read(11'h05A, 1, acks);
    e = exp_q.pop_front();
    n_checks++;
    if (rbuf[0] !== e) begin n_errors++; $display("FAIL arst_readback: got %h, expected %h", rbuf[0], e); end
  endtask

  task automatic test_current_addr();
    int acks;
    for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom_range(0, 255));
    do_write(11'h120, 8, acks);
    wbuf[0] = 8'h77;
    do_write(11'h123, 1, acks);
    expect_bytes(model_ptr, 2);
    do_cur_read(1, acks);
    begin
      logic [7:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (rbuf[0] !== e) begin n_errors++; $display("FAIL cur_read_124: got %h, expected %h", rbuf[0], e); end
      do_cur_read(1, acks);
      e = exp_q.pop_front();
      n_checks++;
      if (rbuf[0] !== e) begin n_errors++; $display("FAIL cur_read_125: got %h, expected %h", rbuf[0], e); end
    end
    n_checks++;
    if (acks !== 1) begin n_errors++; $display("FAIL cur_read_acks: got %0d, expected 1", acks); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) begin
      int acks, n;
      logic [10:0] a;
      a = 11'($urandom_range(0, 2047));
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
      do_write(a, n, acks);
      n_checks++;
      if (acks !== n + 2) begin n_errors++; $display("FAIL b2b_wr_acks[%0d]: got %0d, expected %0d", k, acks, n + 2); end
      expect_bytes(a, n);
      do_rand_read(a, n, acks);
      n_checks++;
      if (acks !== 3) begin n_errors++; $display("FAIL b2b_rd_acks[%0d]: got %0d, expected 3", k, acks); end
      for (int i = 0; i < n; i++) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        n_checks++;
        if (rbuf[i] !== e) begin
          n_errors++; $display("FAIL b2b_data[%0d][%0d] addr %h: got %h, expected %h", k, i, a, rbuf[i], e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_random_read();
    test_wrap();
    test_wrong_id();
    test_stop_mid_byte();
    test_async_reset();
    test_current_addr();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
